// File: rtl/tone_synth_pkg.sv
// Shared types, the C5..C6 half-period table (50 MHz clock) and ASCII label helpers
// for the programmable tone synthesiser.
package tone_synth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int TABLE_W   = 20;
  localparam int TABLE_LEN = 8;

  localparam logic [TABLE_W-1:0] HALF_TABLE [TABLE_LEN] = '{
    20'd47801, 20'd42589, 20'd37936, 20'd35817,
    20'd31928, 20'd28409, 20'd25329, 20'd23900
  };

  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_QM = 8'h3F;
  localparam logic [7:0] CH_2  = 8'h32;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_D  = 8'h44;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_F  = 8'h46;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_M  = 8'h4D;
  localparam logic [7:0] CH_N  = 8'h4E;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_LA = 8'h61;
  localparam logic [7:0] CH_LE = 8'h65;
  localparam logic [7:0] CH_LI = 8'h69;
  localparam logic [7:0] CH_LO = 8'h6F;

  localparam logic [31:0] LABEL_IDLE = {CH_C, CH_P, CH_E, CH_N};

  // Indices past the table reuse the top note so extended builds still sound.
  function automatic logic [TABLE_W-1:0] table_entry(input int idx);
    if (idx < TABLE_LEN) return HALF_TABLE[idx[2:0]];
    return HALF_TABLE[TABLE_LEN-1];
  endfunction

  function automatic logic [31:0] note_label(input int idx);
    case (idx)
      0:       return {CH_SP, CH_D, CH_LO, CH_SP};
      1:       return {CH_SP, CH_R, CH_LE, CH_SP};
      2:       return {CH_SP, CH_M, CH_LI, CH_SP};
      3:       return {CH_SP, CH_F, CH_LA, CH_SP};
      4:       return {CH_SP, CH_S, CH_LO, CH_SP};
      5:       return {CH_SP, CH_L, CH_LA, CH_SP};
      6:       return {CH_SP, CH_S, CH_LI, CH_SP};
      7:       return {CH_SP, CH_D, CH_LO, CH_2};
      default: return {CH_SP, CH_QM, CH_QM, CH_SP};
    endcase
  endfunction

endpackage

// File: rtl/tone_synth_half_period_counter.sv
// Half-period counter: load clears the count and captures a new half-period,
// run advances it, tc flags the last cycle of the current half-period.
module half_period_counter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] half,
  output logic             tc
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] half_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      half_q <= '0;
    end else if (load) begin
      count  <= '0;
      half_q <= half;
    end else if (run) begin
      count  <= count + CNT_W'(1);
    end
  end

  assign tc = (count == half_q - CNT_W'(1));

endmodule

// File: rtl/tone_synth.sv
// Programmable square-wave tone generator: note table lookup with octave shift,
// note changes applied only at half-period boundaries, and a drain on mute.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int NUM_NOTES = 8,
  parameter int CNT_W     = 20,
  parameter int OCT_W     = 2,
  parameter int SIM_SHIFT = 0,
  parameter int MIN_HALF  = 2
) (
  input  logic                         CLOCK_50,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [$clog2(NUM_NOTES)-1:0] note_sel,
  input  logic [OCT_W-1:0]             octave,
  output logic                         tone_out,
  output logic                         sample_tick,
  output logic [$clog2(NUM_NOTES)-1:0] cur_note,
  output logic [31:0]                  label,
  output logic                         busy,
  output state_t                       dbg_state
);

  state_t           state, state_nxt;
  logic             req;
  logic             tc;
  logic             load, run, take_note;
  logic             tone_nxt, tick_nxt;
  logic [TABLE_W-1:0] entry_raw, entry_oct;
  logic [CNT_W-1:0] half_calc;

  // An out-of-range index is a mute request, same as enable low.
  assign req = enable && (int'(note_sel) < NUM_NOTES);

  always_comb begin
    entry_raw = table_entry(int'(note_sel)) >> SIM_SHIFT;
    entry_oct = entry_raw >> octave;
    if (entry_oct < TABLE_W'(MIN_HALF)) half_calc = CNT_W'(MIN_HALF);
    else                                half_calc = CNT_W'(entry_oct);
  end

  half_period_counter #(.CNT_W(CNT_W)) u_counter (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .load  (load),
    .run   (run),
    .half  (half_calc),
    .tc    (tc)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = RUN;
      RUN: begin
        if (!req) begin
          if (!tone_out || tc) state_nxt = IDLE;
          else                 state_nxt = DRAIN;
        end
      end
      DRAIN:   if (tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every path back to IDLE or into a new half-period reloads the counter.
  always_comb begin
    load      = 1'b0;
    run       = 1'b0;
    take_note = 1'b0;
    tone_nxt  = tone_out;
    tick_nxt  = 1'b0;
    case (state)
      IDLE: begin
        load     = 1'b1;
        tone_nxt = 1'b0;
        if (req) begin
          tone_nxt  = 1'b1;
          tick_nxt  = 1'b1;
          take_note = 1'b1;
        end
      end
      RUN: begin
        if (!req) begin
          if (!tone_out || tc) begin
            load     = 1'b1;
            tone_nxt = 1'b0;
          end else begin
            run = 1'b1;
          end
        end else if (tc) begin
          load      = 1'b1;
          take_note = 1'b1;
          tone_nxt  = !tone_out;
          tick_nxt  = !tone_out;
        end else begin
          run = 1'b1;
        end
      end
      DRAIN: begin
        if (tc) begin
          load     = 1'b1;
          tone_nxt = 1'b0;
        end else begin
          run = 1'b1;
        end
      end
      default: begin
        load     = 1'b1;
        tone_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      tone_out    <= 1'b0;
      sample_tick <= 1'b0;
      cur_note    <= '0;
      label       <= LABEL_IDLE;
    end else begin
      tone_out    <= tone_nxt;
      sample_tick <= tick_nxt;
      if (take_note) begin
        cur_note <= note_sel;
        label    <= note_label(int'(note_sel));
      end else if (state_nxt == IDLE) begin
        label    <= LABEL_IDLE;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
